mem_port_arbiter: RTL and testbench

Shares one single-ported, synchronous-read data/instruction memory between the pipelined CPU's instruction-fetch port and data port. The block arbitrates per cycle, drives the memory, and routes each 1-cycle-latency read response back to its owner. The CPU treats a deasserted grant as a stall for the requesting stage.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_arb_pick.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared constants for the fetch/data memory port arbiter: response owner
// encoding, last-grant encoding and default widths.
package mem_port_arbiter_pkg;

  // Response owner tag, registered with each read grant.
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  // Who received the most recent grant (round-robin history).
  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  // Default widths.
  localparam int AW_DEF          = 32;
  localparam int MAW_DEF         = 10;
  localparam int DW_DEF          = 32;
  localparam int MAX_D_BURST_DEF = 4;

  // Counter width able to hold 0..max inclusive.
  function automatic int burst_w(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick
// Pure combinational arbitration decision between fetch and data requests.
// Build option: MEM_ARB_RR_EN
//   defined   -> round-robin; on conflict the side not granted last wins.
//   undefined -> data priority; fetch wins a conflict once d_burst has
//                reached MAX_D_BURST.
// Ports:
//   i_req, d_req  requests from fetch and data ports
//   last_grant    LG_I / LG_D, side granted most recently
//   d_burst       consecutive data grants made while fetch was waiting
//   i_sel, d_sel  one-hot (or zero) selection
module arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_BURST = MAX_D_BURST_DEF,
  parameter int BW          = burst_w(MAX_D_BURST_DEF)
) (
  input  logic          i_req,
  input  logic          d_req,
  input  logic          last_grant,
  input  logic [BW-1:0] d_burst,
  output logic          i_sel,
  output logic          d_sel
);

`ifdef MEM_ARB_RR_EN
  logic i_wins;
  logic unused_burst;

  assign i_wins       = (last_grant == LG_D);
  assign unused_burst = ^d_burst;
`else
  localparam logic [BW-1:0] MAX_B = BW'(MAX_D_BURST);

  logic i_wins;
  logic unused_last_grant;

  // Starvation guard: fetch takes the conflict once data has had its run.
  assign i_wins            = (d_burst == MAX_B);
  assign unused_last_grant = last_grant;
`endif

  assign i_sel = i_req & (~d_req | i_wins);
  assign d_sel = d_req & (~i_req | ~i_wins);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported synchronous-read memory between the CPU fetch port
// and data port. One grant per cycle (combinational), 1-cycle read latency,
// responses routed back by a registered owner tag.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration (see arb_pick);
// default build is data priority with a fetch starvation guard.
// Ports:
//   clock, reset                  rising-edge clock, sync active-high reset
//   i_req/i_addr/i_gnt            fetch request, byte address, grant
//   i_rvalid/i_rdata              fetch response (rdata held between pulses)
//   d_req/d_we/d_addr/d_wdata     data request, write flag, address, store data
//   d_gnt/d_rvalid/d_rdata        data grant and load response
//   m_en/m_we/m_addr/m_wdata      memory command
//   m_rdata                       memory read data (valid cycle after read)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int MAW         = MAW_DEF,
  parameter int DW          = DW_DEF,
  parameter int MAX_D_BURST = MAX_D_BURST_DEF
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           i_req,
  input  logic [AW-1:0]  i_addr,
  output logic           i_gnt,
  output logic           i_rvalid,
  output logic [DW-1:0]  i_rdata,
  input  logic           d_req,
  input  logic           d_we,
  input  logic [AW-1:0]  d_addr,
  input  logic [DW-1:0]  d_wdata,
  output logic           d_gnt,
  output logic           d_rvalid,
  output logic [DW-1:0]  d_rdata,
  output logic           m_en,
  output logic           m_we,
  output logic [MAW-1:0] m_addr,
  output logic [DW-1:0]  m_wdata,
  input  logic [DW-1:0]  m_rdata
);

  localparam int            BW    = burst_w(MAX_D_BURST);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_D_BURST);

  logic           i_sel;
  logic           d_sel;
  logic           last_grant;
  logic [BW-1:0]  d_burst;
  logic [1:0]     rsp_owner;
  logic [MAW-1:0] addr_q;
  logic [DW-1:0]  wdata_q;
  logic [DW-1:0]  i_rdata_q;
  logic [DW-1:0]  d_rdata_q;
  logic           unused_addr_bits;

  arb_pick #(
    .MAX_D_BURST (MAX_D_BURST),
    .BW          (BW)
  ) u_arb_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .d_burst    (d_burst),
    .i_sel      (i_sel),
    .d_sel      (d_sel)
  );

  assign i_gnt = i_sel & ~reset;
  assign d_gnt = d_sel & ~reset;

  // Memory command; address and write data hold when idle.
  assign m_en    = i_gnt | d_gnt;
  assign m_we    = d_gnt & d_we;
  assign m_addr  = d_gnt ? d_addr[MAW+1:2] :
                   i_gnt ? i_addr[MAW+1:2] : addr_q;
  assign m_wdata = m_we ? d_wdata : wdata_q;

  // m_rdata is only valid in the response cycle, so it is passed straight
  // through then and captured for holding afterwards. Reset kills a response
  // that is in flight.
  assign i_rvalid = (rsp_owner == OWN_I) & ~reset;
  assign d_rvalid = (rsp_owner == OWN_D) & ~reset;
  assign i_rdata  = i_rvalid ? m_rdata : i_rdata_q;
  assign d_rdata  = d_rvalid ? m_rdata : d_rdata_q;

  assign unused_addr_bits = ^{i_addr[1:0], i_addr[AW-1:MAW+2],
                              d_addr[1:0], d_addr[AW-1:MAW+2]};

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_owner  <= OWN_NONE;
      last_grant <= LG_I;
      d_burst    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      addr_q  <= m_addr;
      wdata_q <= m_wdata;

      if (i_gnt)
        rsp_owner <= OWN_I;
      else if (d_gnt && !d_we)
        rsp_owner <= OWN_D;
      else
        rsp_owner <= OWN_NONE;

      if (i_rvalid) i_rdata_q <= m_rdata;
      if (d_rvalid) d_rdata_q <= m_rdata;

      if (i_gnt)
        last_grant <= LG_I;
      else if (d_gnt)
        last_grant <= LG_D;

      // Counts data grants taken while fetch waits; saturates at MAX_B.
      if (i_gnt || !i_req)
        d_burst <= '0;
      else if (d_gnt && d_burst != MAX_B)
        d_burst <= d_burst + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic        m_we;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  logic [31:0] mem [0:1023];

  int n_checks;
  int n_pass;

  mem_port_arbiter dut (
    .clock    (clock),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read single-port memory; a few words preloaded in reset.
  always @(posedge clock) begin
    if (reset) begin
      mem[0]  <= 32'hCAFE_0001;
      mem[4]  <= 32'hDEAD_BEEF;
      m_rdata <= 32'h0;
    end else if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clock);
  endtask

  logic [5:0] exp_d;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    i_req    = 1'b0;
    i_addr   = 32'h0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = 32'h0;
    d_wdata  = 32'h0;

    // Reset values, with requests asserted to show grants are forced low.
    next_cycle();
    next_cycle();
    i_req = 1'b1;
    d_req = 1'b1;
    at_sample();
    check("rst_i_gnt",    i_gnt,    0);
    check("rst_d_gnt",    d_gnt,    0);
    check("rst_i_rvalid", i_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_i_rdata",  i_rdata,  0);
    check("rst_d_rdata",  d_rdata,  0);
    check("rst_m_en",     m_en,     0);
    check("rst_m_we",     m_we,     0);
    check("rst_m_addr",   m_addr,   0);
    check("rst_m_wdata",  m_wdata,  0);

    // Fetch only from 0x10 (word 4).
    next_cycle();
    reset  = 1'b0;
    d_req  = 1'b0;
    i_req  = 1'b1;
    i_addr = 32'h10;
    for (int c = 0; c < 3; c++) begin
      at_sample();
      check("fetch_i_gnt",    i_gnt,    1);
      check("fetch_d_gnt",    d_gnt,    0);
      check("fetch_m_addr",   m_addr,   4);
      check("fetch_m_en",     m_en,     1);
      check("fetch_i_rvalid", i_rvalid, (c > 0) ? 1 : 0);
      if (c > 0) check("fetch_i_rdata", i_rdata, 32'hDEAD_BEEF);
      check("fetch_d_rvalid", d_rvalid, 0);
      next_cycle();
    end
    i_req = 1'b0;
    at_sample();
    check("fetch_last_rvalid", i_rvalid, 1);
    check("fetch_last_rdata",  i_rdata,  32'hDEAD_BEEF);
    check("idle_m_en",         m_en,     0);
    check("idle_m_addr_hold",  m_addr,   4);
    next_cycle();
    at_sample();
    check("idle_i_rvalid",     i_rvalid, 0);
    check("idle_i_rdata_hold", i_rdata,  32'hDEAD_BEEF);

    // Store 0x12345678 to 0x20, then load it back the next cycle.
    next_cycle();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h20;
    d_wdata = 32'h1234_5678;
    at_sample();
    check("st_d_gnt",   d_gnt,   1);
    check("st_m_we",    m_we,    1);
    check("st_m_addr",  m_addr,  8);
    check("st_m_wdata", m_wdata, 32'h1234_5678);
    next_cycle();
    d_we = 1'b0;
    at_sample();
    check("ld_d_gnt",        d_gnt,    1);
    check("ld_m_we",         m_we,     0);
    check("st_no_d_rvalid",  d_rvalid, 0);
    next_cycle();
    d_req = 1'b0;
    at_sample();
    check("ld_d_rvalid", d_rvalid, 1);
    check("ld_d_rdata",  d_rdata,  32'h1234_5678);
    check("ld_i_rvalid", i_rvalid, 0);

    // Both requesting for 6 cycles; bit c = 1 means data wins cycle c.
`ifdef MEM_ARB_RR_EN
    exp_d = 6'b101010;  // last grant was data, so fetch goes first
`else
    exp_d = 6'b101111;  // four data grants, then fetch, then data
`endif
    next_cycle();
    i_req  = 1'b1;
    i_addr = 32'h10;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h20;
    for (int c = 0; c < 6; c++) begin
      at_sample();
      check("cf_d_gnt", d_gnt, exp_d[c]);
      check("cf_i_gnt", i_gnt, !exp_d[c]);
      if (c > 0) begin
        check("cf_d_rvalid", d_rvalid, exp_d[c-1]);
        check("cf_i_rvalid", i_rvalid, !exp_d[c-1]);
        if (exp_d[c-1]) check("cf_d_rdata", d_rdata, 32'h1234_5678);
        else            check("cf_i_rdata", i_rdata, 32'hDEAD_BEEF);
      end
      next_cycle();
    end
    i_req = 1'b0;
    d_req = 1'b0;
    at_sample();
    check("cf_end_d_rvalid", d_rvalid, 1);
    check("cf_end_d_rdata",  d_rdata,  32'h1234_5678);

    // Reset in the cycle after a read grant drops the response.
    next_cycle();
    i_req  = 1'b1;
    i_addr = 32'h10;
    at_sample();
    check("rr_i_gnt", i_gnt, 1);
    next_cycle();
    reset = 1'b1;
    at_sample();
    check("rr_i_rvalid", i_rvalid, 0);
    check("rr_i_gnt_forced", i_gnt, 0);
    check("rr_d_gnt_forced", d_gnt, 0);
    check("rr_m_en",     m_en,     0);
    next_cycle();
    at_sample();
    check("rr_i_rdata",   i_rdata,  0);
    check("rr_d_rdata",   d_rdata,  0);
    check("rr_i_rvalid2", i_rvalid, 0);
    next_cycle();
    reset = 1'b0;
    i_req = 1'b0;
    at_sample();
    check("rr_post_i_rvalid", i_rvalid, 0);
    check("rr_post_d_rvalid", d_rvalid, 0);

    // Address wrap and ignored low bits.
    next_cycle();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h1000;
    at_sample();
    check("wrap_d_gnt",  d_gnt,  1);
    check("wrap_m_addr", m_addr, 0);
    next_cycle();
    d_addr = 32'h1013;
    at_sample();
    check("wrap_d_rvalid", d_rvalid, 1);
    check("wrap_d_rdata",  d_rdata,  32'hCAFE_0001);
    check("lowbit_m_addr", m_addr,   4);
    next_cycle();
    d_req = 1'b0;
    at_sample();
    check("lowbit_d_rvalid", d_rvalid, 1);
    check("lowbit_d_rdata",  d_rdata,  32'hDEAD_BEEF);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
